// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and glyph table for the column-multiplexed matrix scanner.
// IMAGE_ROM[image][k] gives the 7-bit row pattern for column index k (k=0 is the outer pair).
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  typedef logic [1:0] image_t;
  typedef logic [6:0] row_t;

  // Image 0 is dark so that a freshly reset display shows nothing.
  localparam row_t IMAGE_ROM [4][3] = '{
    '{7'h00, 7'h00, 7'h00},
    '{7'h11, 7'h22, 7'h44},
    '{7'h3E, 7'h41, 7'h3E},
    '{7'h7F, 7'h08, 7'h7F}
  };

endpackage

// File: rtl/image_rom.sv
// image_rom: combinational row-pattern lookup for one image and one column index.
module image_rom
  import matrix_pkg::*;
(
  input  image_t     image,
  input  logic [1:0] col_idx,
  output row_t       rows
);

  // Column index 3 never occurs in the scan; it reads as dark rather than out of range.
  always_comb begin
    rows = '0;
    if (col_idx != 2'd3) rows = IMAGE_ROM[image][col_idx];
  end

endmodule

// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: scans a 3-column mirrored LED matrix, one column slot of
// DIVIDER clocks at a time, and swaps the displayed image only at frame boundaries.
// Build macro MATRIX_SCAN_BLANK_EN: when defined, each slot opens with BLANK_CYCLES
// rows-off cycles (ghosting guard); when undefined, slots are pure DRIVE.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | scan disabled, col=000, rows=0, column index and counter cleared
//   ST_BLANK | column k selected, rows forced off for BLANK_CYCLES cycles
//   ST_DRIVE | column k selected, rows = IMAGE_ROM[cur_image][k]
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int DIVIDER      = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       image_req,
  input  image_t     image_id,
  output logic       image_ack,
  output logic [2:0] col,
  output row_t       rows,
  output logic       frame_done
);

  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);

`ifdef MATRIX_SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam state_e SLOT_START = ST_BLANK;
`else
  localparam state_e SLOT_START = ST_DRIVE;
`endif

  if (DIVIDER < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= DIVIDER) begin : g_bad_params
    $error("matrix_scan_controller: need 1 <= BLANK_CYCLES < DIVIDER");
  end

  state_e             state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  image_t             cur_image_q, cur_image_d;
  logic [2:0]         col_q, col_d;
  row_t               rows_q, rows_d;
  logic               frame_done_q, frame_done_d;
  logic               image_ack_q, image_ack_d;
  logic               boundary;
  row_t               rom_rows;

  // Looked up with next-state values so the registered rows line up with col.
  image_rom u_image_rom (
    .image   (cur_image_d),
    .col_idx (k_d),
    .rows    (rom_rows)
  );

  // Slot sequencing, column advance, and boundary-only image latch.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    cur_image_d = cur_image_q;
    boundary    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      k_d     = 2'd0;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = SLOT_START;
      k_d     = 2'd0;
      cnt_d   = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d  = SLOT_START;
      cnt_d    = '0;
      k_d      = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
      boundary = (k_q == 2'd2);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
`ifdef MATRIX_SCAN_BLANK_EN
      if (state_q == ST_BLANK && cnt_q == BLANK_LAST) state_d = ST_DRIVE;
`endif
    end
    if (boundary && image_req) cur_image_d = image_id;
  end

  // Output decode from the next state so every output is a plain flop.
  always_comb begin
    col_d        = (state_d == ST_IDLE) ? 3'b000 : (3'b100 >> k_d);
    rows_d       = (state_d == ST_DRIVE) ? rom_rows : '0;
    frame_done_d = boundary;
    image_ack_d  = boundary & image_req;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      k_q          <= 2'd0;
      cnt_q        <= '0;
      cur_image_q  <= '0;
      col_q        <= 3'b000;
      rows_q       <= '0;
      frame_done_q <= 1'b0;
      image_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      cur_image_q  <= cur_image_d;
      col_q        <= col_d;
      rows_q       <= rows_d;
      frame_done_q <= frame_done_d;
      image_ack_q  <= image_ack_d;
    end
  end

  assign col        = col_q;
  assign rows       = rows_q;
  assign frame_done = frame_done_q;
  assign image_ack  = image_ack_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// tb_matrix_scan_controller: directed bench for the matrix scanner, DIVIDER=8, BLANK_CYCLES=2.
// Expected outputs come from a frame-position model plus a hand-written glyph table.
module tb_matrix_scan_controller;

  localparam int DIV = 8;
`ifdef MATRIX_SCAN_BLANK_EN
  localparam int BL = 2;
`else
  localparam int BL = 0;
`endif
  localparam int FRAME = 3 * DIV;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       image_req;
  logic [1:0] image_id;
  logic       image_ack;
  logic [2:0] col;
  logic [6:0] rows;
  logic       frame_done;

  int checks = 0;
  int fails  = 0;

  int         m_pos;
  logic [1:0] m_img;
  logic       m_fd;
  logic       m_ack;

  matrix_scan_controller #(.DIVIDER(DIV), .BLANK_CYCLES(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .image_req  (image_req),
    .image_id   (image_id),
    .image_ack  (image_ack),
    .col        (col),
    .rows       (rows),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] rom(input logic [1:0] img, input int k);
    logic [6:0] r;
    r = 7'h00;
    case (img)
      2'd1: r = (k == 0) ? 7'h11 : (k == 1) ? 7'h22 : 7'h44;
      2'd2: r = (k == 1) ? 7'h41 : 7'h3E;
      2'd3: r = (k == 1) ? 7'h08 : 7'h7F;
      default: r = 7'h00;
    endcase
    return r;
  endfunction

  // {col, rows, frame_done, image_ack} expected at the current model position.
  function automatic logic [11:0] exp_vec();
    logic [2:0] c;
    logic [6:0] r;
    if (m_pos < 0) begin
      c = 3'b000;
      r = 7'h00;
    end else begin
      c = 3'b100 >> (m_pos / DIV);
      r = ((m_pos % DIV) < BL) ? 7'h00 : rom(m_img, m_pos / DIV);
    end
    return {c, r, m_fd, m_ack};
  endfunction

  // Advance one clock and move the model with the inputs present at that edge.
  task automatic tick();
    logic en, rq, rst;
    logic [1:0] id;
    en = enable; rq = image_req; id = image_id; rst = reset_n;
    @(posedge clock);
    #1;
    m_fd  = 1'b0;
    m_ack = 1'b0;
    if (!rst) begin
      m_pos = -1;
      m_img = 2'd0;
    end else if (!en) begin
      m_pos = -1;
    end else if (m_pos < 0) begin
      m_pos = 0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0;
      m_fd  = 1'b1;
      if (rq) begin
        m_img = id;
        m_ack = 1'b1;
      end
    end else begin
      m_pos++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; image_req = 1'b1; image_id = 2'd3;
    tick();
    tick();
    checks++;
    if (col !== 3'b000) begin fails++; $display("FAIL reset_col got=%b exp=000", col); end
    checks++;
    if (rows !== 7'h00) begin fails++; $display("FAIL reset_rows got=%h exp=00", rows); end
    checks++;
    if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++;
    if (image_ack !== 1'b0) begin fails++; $display("FAIL reset_image_ack got=%b exp=0", image_ack); end
    reset_n = 1'b1; image_req = 1'b0; image_id = 2'd0;
  endtask

  task automatic test_scan();
    int nz;
    nz = 0;
    image_req = 1'b1; image_id = 2'd1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({col, rows, frame_done, image_ack} !== exp_vec())
        begin fails++; $display("FAIL scan i=%0d got col=%b rows=%h fd=%b ack=%b exp=%h", i, col, rows, frame_done, image_ack, exp_vec()); end
      if (i == 0) begin
        checks++;
        if ({col, frame_done} !== 4'b1000) begin fails++; $display("FAIL scan_entry got col=%b fd=%b exp col=100 fd=0", col, frame_done); end
      end
      if (i == FRAME) begin
        checks++;
        if ({frame_done, image_ack} !== 2'b11) begin fails++; $display("FAIL scan_boundary got fd=%b ack=%b exp 11", frame_done, image_ack); end
        image_req = 1'b0;
      end
      if (i >= FRAME && rows !== 7'h00) nz++;
    end
    checks++;
    if (nz !== 3 * (DIV - BL)) begin fails++; $display("FAIL scan_lit_cycles got=%0d exp=%0d", nz, 3 * (DIV - BL)); end
  endtask

  task automatic test_image_change();
    int acks;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({col, rows, frame_done, image_ack} !== exp_vec())
        begin fails++; $display("FAIL chg_pre i=%0d got col=%b rows=%h fd=%b ack=%b exp=%h", i, col, rows, frame_done, image_ack, exp_vec()); end
    end
    image_req = 1'b1; image_id = 2'd3;
    for (int i = 0; i < FRAME - 10; i++) begin
      tick();
      if (image_ack === 1'b1) acks++;
      checks++;
      if ({col, rows, frame_done, image_ack} !== exp_vec())
        begin fails++; $display("FAIL chg_wait i=%0d got col=%b rows=%h fd=%b ack=%b exp=%h", i, col, rows, frame_done, image_ack, exp_vec()); end
    end
    checks++;
    if (acks !== 0) begin fails++; $display("FAIL chg_early_ack got=%0d exp=0", acks); end
    tick();
    checks++;
    if ({frame_done, image_ack} !== 2'b11) begin fails++; $display("FAIL chg_boundary got fd=%b ack=%b exp 11", frame_done, image_ack); end
    image_req = 1'b0;
    repeat (BL) tick();
    checks++;
    if ({col, rows} !== {3'b100, 7'h7F}) begin fails++; $display("FAIL chg_new_image got col=%b rows=%h exp col=100 rows=7f", col, rows); end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < DIV + 1; i++) begin
      tick();
      checks++;
      if ({col, rows, frame_done, image_ack} !== exp_vec())
        begin fails++; $display("FAIL en_pre i=%0d got col=%b rows=%h fd=%b ack=%b exp=%h", i, col, rows, frame_done, image_ack, exp_vec()); end
    end
    checks++;
    if ({col, rows} !== {3'b010, 7'h08}) begin fails++; $display("FAIL en_in_drive got col=%b rows=%h exp col=010 rows=08", col, rows); end
    enable = 1'b0;
    tick();
    checks++;
    if ({col, rows} !== 10'd0) begin fails++; $display("FAIL en_drop got col=%b rows=%h exp 0", col, rows); end
    tick();
    checks++;
    if ({col, rows, frame_done, image_ack} !== exp_vec())
      begin fails++; $display("FAIL en_idle got col=%b rows=%h fd=%b ack=%b exp=%h", col, rows, frame_done, image_ack, exp_vec()); end
    enable = 1'b1;
    tick();
    checks++;
    if ({col, frame_done} !== 4'b1000) begin fails++; $display("FAIL en_restart got col=%b fd=%b exp col=100 fd=0", col, frame_done); end
    checks++;
    if ({col, rows, frame_done, image_ack} !== exp_vec())
      begin fails++; $display("FAIL en_restart_vec got col=%b rows=%h fd=%b ack=%b exp=%h", col, rows, frame_done, image_ack, exp_vec()); end
  endtask

  task automatic test_reset_mid();
    int nz;
    nz = 0;
    for (int i = 0; i < DIV + BL + 2; i++) begin
      tick();
      checks++;
      if ({col, rows, frame_done, image_ack} !== exp_vec())
        begin fails++; $display("FAIL rst_pre i=%0d got col=%b rows=%h fd=%b ack=%b exp=%h", i, col, rows, frame_done, image_ack, exp_vec()); end
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if ({col, rows, frame_done, image_ack} !== 12'd0)
      begin fails++; $display("FAIL rst_mid got col=%b rows=%h fd=%b ack=%b exp all 0", col, rows, frame_done, image_ack); end
    reset_n = 1'b1;
    for (int i = 0; i < FRAME + 1; i++) begin
      tick();
      if (rows !== 7'h00) nz++;
      checks++;
      if ({col, rows, frame_done, image_ack} !== exp_vec())
        begin fails++; $display("FAIL rst_post i=%0d got col=%b rows=%h fd=%b ack=%b exp=%h", i, col, rows, frame_done, image_ack, exp_vec()); end
    end
    checks++;
    if (nz !== 0) begin fails++; $display("FAIL rst_dark_frame got=%0d lit cycles exp=0", nz); end
  endtask

  task automatic test_back_to_back();
    int acks, paired, doubles;
    logic prev_ack;
    acks = 0; paired = 0; doubles = 0; prev_ack = 1'b0;
    image_req = 1'b1; image_id = 2'd2;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (image_ack === 1'b1) begin
        acks++;
        if (frame_done === 1'b1) paired++;
        if (prev_ack) doubles++;
      end
      prev_ack = image_ack;
      checks++;
      if ({col, rows, frame_done, image_ack} !== exp_vec())
        begin fails++; $display("FAIL b2b i=%0d got col=%b rows=%h fd=%b ack=%b exp=%h", i, col, rows, frame_done, image_ack, exp_vec()); end
    end
    image_req = 1'b0;
    checks++;
    if (acks !== 3) begin fails++; $display("FAIL b2b_ack_count got=%0d exp=3", acks); end
    checks++;
    if (paired !== 3 || doubles !== 0) begin fails++; $display("FAIL b2b_ack_shape got paired=%0d doubles=%0d exp 3/0", paired, doubles); end
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      checks++;
      if ({col, rows, frame_done, image_ack} !== exp_vec())
        begin fails++; $display("FAIL b2b_hold i=%0d got col=%b rows=%h fd=%b ack=%b exp=%h", i, col, rows, frame_done, image_ack, exp_vec()); end
    end
  endtask

  initial begin
    m_pos = -1; m_img = 2'd0; m_fd = 1'b0; m_ack = 1'b0;
    reset_n = 1'b0; enable = 1'b0; image_req = 1'b0; image_id = 2'd0;
    test_reset();
    test_scan();
    test_image_change();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/matrix_scan_controller.md
MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

Interface
REQ-001 SHALL have parameter DIVIDER, default 1000, clock cycles per column slot (blank plus drive).
REQ-002 SHALL have parameter BLANK_CYCLES, default 4, rows-off cycles at the start of each slot; legal range 1 <= BLANK_CYCLES < DIVIDER.
REQ-003 SHALL have port: clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port: enable  input  1  scan enable, level.
REQ-006 SHALL have port: image_req  input  1  request to change the displayed image, level.
REQ-007 SHALL have port: image_id  input  2  requested image index, valid while image_req is high.
REQ-008 SHALL have port: image_ack  output  1  one-cycle pulse when image_id is latched.
REQ-009 SHALL have port: col  output  3  one-hot column select; col[2] is the outer mirrored pair, col[0] is the centre column.
REQ-010 SHALL have port: rows  output  7  row drive, active-high.
REQ-011 SHALL have port: frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL implement the states IDLE, BLANK and DRIVE.
REQ-013 SHALL keep a column index k (0..2) and drive col = 3'b100 >> k in BLANK and DRIVE, giving the sequence 100, 010, 001, 100, ...
REQ-014 SHALL drive rows = 0 in IDLE and BLANK, and rows = IMAGE_ROM[cur_image][k] in DRIVE.
REQ-015 SHALL stay in BLANK for BLANK_CYCLES cycles, then in DRIVE for DIVIDER-BLANK_CYCLES cycles, then advance k (2 wraps to 0) and re-enter BLANK.
REQ-016 SHALL, in IDLE with enable high, enter BLANK with k=0 on the next cycle.
REQ-017 SHALL, whenever enable is low, enter IDLE on the next cycle: col=000, rows=0, k=0, slot counter cleared; re-enable restarts at k=0 BLANK.
REQ-018 SHALL assert frame_done for exactly the first cycle of BLANK with k=0 that follows DRIVE with k=2; it SHALL NOT assert on the IDLE->BLANK entry.
REQ-019 SHALL latch image_id into cur_image only in a frame_done cycle while image_req is high, and pulse image_ack in that same cycle; the new image SHALL take effect from the DRIVE of k=0 in that frame.
REQ-020 SHALL hold cur_image while image_req is low; a request still held at the next boundary SHALL be accepted again.
REQ-021 SHALL size the slot counter to $clog2(DIVIDER) bits, counting 0..DIVIDER-1 and wrapping at the end of each slot.
REQ-022 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-023 SHALL, in any cycle with reset_n low, go to IDLE with k=0, counter=0, cur_image=0, col=000, rows=0, image_ack=0, frame_done=0; reset SHALL override enable and image_req, including mid-slot.

Configuration
REQ-024 SHALL honour macro MATRIX_SCAN_BLANK_EN: when defined, BLANK is implemented per REQ-015; when undefined, BLANK_CYCLES SHALL be ignored, BLANK SHALL be omitted, every slot SHALL be DIVIDER DRIVE cycles, and frame_done/image_ack SHALL fire on the first DRIVE cycle of k=0 after k=2.

Structure
REQ-025 SHALL take from the shared package matrix_pkg the state enum, the image index typedef (2 bits), the row pattern typedef (7 bits), and the constant IMAGE_ROM[4][3] (image 0 all zeros).
REQ-026 SHALL place the pattern lookup in a sub-module image_rom (inputs image, column index; output rows pattern).

Verification
REQ-027 SHALL cover: DIVIDER=8, BLANK_CYCLES=2, enable high after reset -> col cycles 100/010/001 every 8 cycles; rows=0 for 2 cycles then pattern for 6 cycles.
REQ-028 SHALL cover: image_req=1 with image_id=3 raised mid-frame -> no ack until the boundary; image_ack and frame_done coincide; IMAGE_ROM[3][0] appears 2 cycles later.
REQ-029 SHALL cover: enable dropped during DRIVE with k=1 -> next cycle col=000, rows=0; re-enable -> BLANK with col=100 and no frame_done.
REQ-030 SHALL cover: reset_n low for 1 cycle mid-DRIVE -> all outputs 0 next cycle and cur_image=0, so rows read 0 throughout the next frame.
REQ-031 SHALL cover: image_req held high for 3 frames with image_id=2 -> exactly 3 single-cycle image_ack pulses, one per boundary.
REQ-032 SHALL cover: build without MATRIX_SCAN_BLANK_EN, DIVIDER=8 -> rows nonzero (image 1) for all 8 cycles of each slot.
